// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: queues ALU commands, issues them one at a time to an external
// fixed-latency ALU and holds each captured result until the consumer accepts it.
module alu_issue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_opcode,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    output logic [7:0] alu_opcode,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_z,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_z,
    output logic [7:0] out_opcode,
    output logic       busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [3:0] LAT = 4'(ALU_LAT);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t        state;
    logic [23:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [3:0]    cnt;
    logic          armed;
    logic          push, pop;

    // armed keeps in_ready low until the first edge after reset release
    assign in_ready = armed && count != FULL;
    assign push     = in_valid && in_ready;
    assign pop      = state == IDLE && count != '0;
    assign busy     = state != IDLE || count != '0;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {in_opcode, in_a, in_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            armed      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            cnt        <= '0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            out_valid  <= 1'b0;
            out_z      <= '0;
            out_opcode <= '0;
        end else begin
            armed <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            case (state)
                IDLE: if (pop) begin
                    {alu_opcode, alu_a, alu_b} <= mem[rd_ptr];
                    cnt   <= LAT;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == 4'd1) begin
                        out_z      <= alu_z;
                        out_opcode <= alu_opcode;
                        out_valid  <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter DEPTH, 4, command FIFO entries; power of two, 2 to 16.
REQ-002 Parameter ALU_LAT, 2, clock edges from alu_opcode/alu_a/alu_b change to alu_z valid; range 1 to 15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  command offered.
REQ-006 in_ready  output  1  command FIFO can accept.
REQ-007 in_opcode  input  8  ALU opcode of offered command.
REQ-008 in_a  input  8  operand a.
REQ-009 in_b  input  8  operand b.
REQ-010 alu_opcode  output  8  opcode driven to downstream ALU, registered.
REQ-011 alu_a  output  8  operand a to ALU, registered.
REQ-012 alu_b  output  8  operand b to ALU, registered.
REQ-013 alu_z  input  8  ALU result.
REQ-014 out_valid  output  1  result available.
REQ-015 out_ready  input  1  consumer accepts result.
REQ-016 out_z  output  8  captured result, registered.
REQ-017 out_opcode  output  8  opcode that produced out_z, registered.
REQ-018 busy  output  1  high when state is not IDLE or FIFO is not empty.

Function
REQ-019 Push occurs on an edge with in_valid and in_ready both high; FIFO stores {opcode,a,b}; write pointer wraps modulo DEPTH.
REQ-020 in_ready is high iff FIFO occupancy is below DEPTH; it depends only on registered occupancy, not on a same-cycle pop.
REQ-021 Full FIFO with same-cycle pop: push is rejected (in_ready already low); occupancy drops by one.
REQ-022 Empty FIFO with same-cycle push: entry is stored; no pop occurs that edge; occupancy becomes 1.
REQ-023 FSM states IDLE, WAIT, HOLD; reset state IDLE.
REQ-024 IDLE with occupancy > 0: on the edge, pop head, load alu_opcode/alu_a/alu_b from it, load latency counter with ALU_LAT, go WAIT.
REQ-025 IDLE with occupancy 0: remain IDLE; ALU outputs hold their last values.
REQ-026 WAIT: counter decrements each edge; on the edge where counter equals 1, capture alu_z into out_z and alu_opcode into out_opcode, set out_valid, go HOLD.
REQ-027 alu_opcode/alu_a/alu_b stay constant from issue until the next issue.
REQ-028 HOLD: out_valid, out_z and out_opcode stay constant while out_ready is low.
REQ-029 HOLD with out_ready high: on the edge, clear out_valid, go IDLE; next issue happens on the following edge at the earliest.
REQ-030 Latency: command pushed at edge E0 into an empty, idle block -> issued at E1, out_valid high after edge E1+ALU_LAT.
REQ-031 Throughput: at most one command per ALU_LAT+2 edges; order of results equals push order.
REQ-032 Arithmetic is not performed in this block; out_z is alu_z exactly as sampled.

Reset
REQ-033 rst_n low immediately forces: state IDLE, occupancy 0, pointers 0, counter 0, alu_opcode/alu_a/alu_b 0x00, out_z/out_opcode 0x00, out_valid 0, busy 0.
REQ-034 in_ready is 0 while rst_n is low and 1 from the first edge after release.
REQ-035 Reset asserted mid-WAIT or mid-HOLD discards the in-flight command and all queued commands; no result is emitted for them.

Verification
REQ-036 Single command: push opcode 0x80, a=16, b=4 with ALU model returning a/b=4 after ALU_LAT=2 -> alu_a=16, alu_b=4 one edge after push; out_valid with out_z=0x04, out_opcode=0x80 three edges after push.
REQ-037 Fill: out_ready low, push 6 commands back-to-back -> first issues, next 4 fill FIFO, in_ready low; 6th held until a pop; all 6 results emerge in push order.
REQ-038 Backpressure: hold out_ready low 10 cycles in HOLD while alu_z changes -> out_valid, out_z, out_opcode unchanged; release -> out_valid low one edge later.
REQ-039 Full plus pop: FIFO full, block pops on same edge in_valid high -> push rejected, occupancy DEPTH-1, in_ready high next cycle.
REQ-040 Reset mid-WAIT: 3 commands queued, assert rst_n low during WAIT -> all outputs 0x00/0 immediately, no result after release, busy 0.
REQ-041 ALU_LAT=1 build: single command -> out_valid two edges after push.
